// File: rtl/i2c_controller.sv
// Single-initiator I2C byte engine: optional START / repeated START, 8 data bits plus ACK, optional STOP.
// Pad enables are registered so reset releases both lines immediately; bus inputs are double-synchronised.
module i2c_controller #(
  parameter logic [4:0] CLK_DIV = 5'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_read,
  input  logic       cmd_stop,
  input  logic       cmd_nack,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       ack_received,
  output logic       done,
  output logic       busy,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_q, w_q_nxt;
  logic [3:0]  r_bit, w_bit_nxt;
  logic        r_rs, w_rs_nxt;
  logic [4:0]  r_cnt;
  logic [1:0]  r_scl_sync, r_sda_sync;
  logic        r_rd, r_stop, r_nack;
  logic [7:0]  r_wr, r_rd_data;
  logic        r_ack, r_done, r_scl_oe, r_sda_oe;
  logic        w_scl, w_sda, w_accept, w_wait, w_tick, w_reload, w_sample, w_bitval;
  logic        w_done, w_scl_oe, w_sda_oe;

  assign w_scl        = r_scl_sync[1];
  assign w_sda        = r_sda_sync[1];
  assign cmd_ready    = (r_state == S_IDLE) || (r_state == S_HOLD);
  assign w_accept     = cmd_valid && cmd_ready;
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign rd_data      = r_rd_data;
  assign ack_received = r_ack;
  assign scl_oe       = r_scl_oe;
  assign sda_oe       = r_sda_oe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_in};
      r_sda_sync <= {r_sda_sync[0], sda_in};
    end
  end

  // Phases where SCL has just been released wait here; the timer reloads until the bus shows SCL high.
  always_comb begin
    w_wait = 1'b0;
    if (!w_scl) begin
      case (r_state)
        S_START: w_wait = r_rs ? (r_q == 2'd1) : (r_q == 2'd0);
        S_BIT:   w_wait = (r_q == 2'd2);
        S_STOP:  w_wait = (r_q == 2'd1);
        default: w_wait = 1'b0;
      endcase
    end
  end

  assign w_reload = (r_state == S_IDLE) || (r_state == S_HOLD) || w_wait || (r_cnt == 5'd0);
  assign w_tick   = (r_cnt == 5'd0) && !w_wait;
  assign w_sample = (r_state == S_BIT) && (r_q == 2'd2) && w_scl && (r_cnt == CLK_DIV - 5'd1);
  assign w_bitval = (r_bit == 4'd0) ? (r_rd && !r_nack) : (!r_rd && !r_wr[r_bit[2:0] - 3'd1]);

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_bit_nxt   = r_bit;
    w_rs_nxt    = r_rs;
    w_done      = 1'b0;
    w_scl_oe    = 1'b0;
    w_sda_oe    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (cmd_start) begin
            w_state_nxt = S_START;
            w_q_nxt     = 2'd0;
            w_rs_nxt    = 1'b0;
          end else begin
            w_done = 1'b1;
          end
        end
      end
      S_HOLD: begin
        w_scl_oe = 1'b1;
        if (w_accept) begin
          w_q_nxt = 2'd0;
          if (cmd_start) begin
            w_state_nxt = S_START;
            w_rs_nxt    = 1'b1;
          end else begin
            w_state_nxt = S_BIT;
            w_bit_nxt   = 4'd8;
          end
        end
      end
      S_START: begin
        if (r_rs) begin
          // Repeated START prologue: raise SDA with SCL low, then raise SCL.
          w_scl_oe = (r_q == 2'd0);
          if (w_tick) begin
            if (r_q == 2'd0) begin
              w_q_nxt = 2'd1;
            end else begin
              w_q_nxt  = 2'd0;
              w_rs_nxt = 1'b0;
            end
          end
        end else begin
          w_sda_oe = 1'b1;
          w_scl_oe = r_q[1];
          if (w_tick) begin
            w_q_nxt = r_q + 2'd1;
            if (r_q == 2'd3) begin
              w_state_nxt = S_BIT;
              w_bit_nxt   = 4'd8;
            end
          end
        end
      end
      S_BIT: begin
        w_sda_oe = w_bitval;
        w_scl_oe = !r_q[1];
        if (w_tick) begin
          w_q_nxt = r_q + 2'd1;
          if (r_q == 2'd3) begin
            if (r_bit != 4'd0) begin
              w_bit_nxt = r_bit - 4'd1;
            end else if (r_stop) begin
              w_state_nxt = S_STOP;
            end else begin
              w_state_nxt = S_HOLD;
              w_done      = 1'b1;
            end
          end
        end
      end
      S_STOP: begin
        w_sda_oe = (r_q != 2'd3);
        w_scl_oe = (r_q == 2'd0);
        if (w_tick) begin
          w_q_nxt = r_q + 2'd1;
          if (r_q == 2'd3) begin
            w_state_nxt = S_IDLE;
            w_done      = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_q      <= 2'd0;
      r_bit    <= 4'd0;
      r_rs     <= 1'b0;
      r_cnt    <= CLK_DIV - 5'd1;
      r_scl_oe <= 1'b0;
      r_sda_oe <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_q      <= w_q_nxt;
      r_bit    <= w_bit_nxt;
      r_rs     <= w_rs_nxt;
      r_cnt    <= w_reload ? (CLK_DIV - 5'd1) : (r_cnt - 5'd1);
      r_scl_oe <= w_scl_oe;
      r_sda_oe <= w_sda_oe;
      r_done   <= w_done;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd      <= 1'b0;
      r_stop    <= 1'b0;
      r_nack    <= 1'b0;
      r_wr      <= 8'h00;
      r_rd_data <= 8'h00;
      r_ack     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rd   <= cmd_read;
        r_stop <= cmd_stop;
        r_nack <= cmd_nack;
        r_wr   <= wr_data;
      end
      if ((r_state == S_IDLE) && w_accept && !cmd_start)
        r_ack <= 1'b1;
      if (w_sample) begin
        if (r_bit == 4'd0) begin
          if (!r_rd) r_ack <= w_sda;
        end else if (r_rd) begin
          r_rd_data <= {r_rd_data[6:0], w_sda};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_controller.sv
// Directed bench for i2c_controller with an open-drain bus and a clocked subordinate model.
// Expected command results are queued on issue and checked when done pulses.
module tb_i2c_controller;
  localparam logic [4:0] K = 5'd4;
  localparam int LIMIT = 1000;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_start = 1'b0, cmd_read = 1'b0, cmd_stop = 1'b0, cmd_nack = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       cmd_ready, ack_received, done, busy, scl_oe, sda_oe;
  logic [7:0] rd_data;
  logic       scl_pull = 1'b0, sda_pull = 1'b0;
  logic       scl_bus, sda_bus;

  assign scl_bus = !(scl_oe || scl_pull);
  assign sda_bus = !(sda_oe || sda_pull);

  always #5 clk = ~clk;

  i2c_controller #(.CLK_DIV(K)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_read(cmd_read), .cmd_stop(cmd_stop), .cmd_nack(cmd_nack),
    .wr_data(wr_data), .rd_data(rd_data), .ack_received(ack_received), .done(done),
    .busy(busy), .scl_in(scl_bus), .sda_in(sda_bus), .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  typedef struct packed {logic rd; logic [7:0] data; logic ack; logic busy;} exp_t;
  exp_t       sb[$];
  logic [8:0] mq[$];
  int         total = 0, bad = 0;

  // Subordinate model: samples the bus on falling clk so simultaneous pad changes never look like START/STOP.
  int         bcnt = 0, stretch = 0, hi_cnt = 0, lo_cnt = 0, st_hi = 0, st_lo = 0;
  int         n_start = 0, n_stop = 0, ndone = 0;
  logic       p_scl = 1'b1, p_sda = 1'b1, m_go = 1'b0, m_rd = 1'b0, m_ack = 1'b1, st_en = 1'b0;
  logic [7:0] m_byte = 8'h00;
  logic [8:0] m_sh = 9'h000;

  always @(negedge clk) begin
    if (p_scl && scl_bus && p_sda && !sda_bus) begin bcnt = 0; m_go = 1'b1; n_start++; end
    if (p_scl && scl_bus && !p_sda && sda_bus) n_stop++;
    if (scl_bus) hi_cnt = p_scl ? hi_cnt + 1 : 1;
    else         lo_cnt = p_scl ? 1 : lo_cnt + 1;
    if (!p_scl && scl_bus) begin
      m_sh = {m_sh[7:0], sda_bus};
      bcnt++;
      if (bcnt == 9) mq.push_back(m_sh);
      if (st_en && bcnt == 5) st_lo = lo_cnt;
    end
    if (p_scl && !scl_bus) begin
      if (st_en && bcnt == 5) st_hi = hi_cnt;
      if (bcnt == 9) begin bcnt = 0; if (m_rd) m_go = 1'b0; end
      if (st_en && bcnt == 4) stretch = 50;
      if (bcnt < 8) sda_pull = m_go && m_rd && !m_byte[7-bcnt];
      else          sda_pull = m_go && !m_rd && m_ack;
    end
    scl_pull = (stretch > 0);
    if (stretch > 0) stretch--;
    p_scl = scl_bus;
    p_sda = sda_bus;
  end

  always @(posedge clk) if (done) ndone++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic rd, input logic [7:0] data, input logic ack, input logic bsy);
    exp_t e;
    e.rd = rd; e.data = data; e.ack = ack; e.busy = bsy;
    sb.push_back(e);
  endtask

  task automatic issue(input logic st, input logic rd, input logic sp, input logic nk, input logic [7:0] wd);
    int n = 0;
    cmd_start = st; cmd_read = rd; cmd_stop = sp; cmd_nack = nk; wr_data = wd; cmd_valid = 1'b1;
    while (!cmd_ready && n < LIMIT) begin @(posedge clk); #1; n++; end
    chk("ready_wait", n < LIMIT, 1);
    @(posedge clk); #1;
    // Scramble the fields right after acceptance; the command must already be captured.
    cmd_valid = 1'b0; cmd_start = ~st; cmd_read = ~rd; cmd_stop = ~sp; cmd_nack = ~nk; wr_data = ~wd;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < LIMIT) begin @(posedge clk); #1; n++; end
    chk({tag, "_done"}, done, 1);
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    e = sb.pop_front();
    if (e.rd) chk({tag, "_rd_data"}, rd_data, e.data);
    else      chk({tag, "_ack"}, ack_received, e.ack);
    chk({tag, "_busy"}, busy, e.busy);
  endtask

  task automatic check_mq(input string tag, input logic [8:0] expv);
    logic [8:0] v;
    v = 'x;
    if (mq.size() > 0) v = mq.pop_front();
    chk({tag, "_bus_bits"}, v, expv);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int d0, s0, p0;

  initial begin
    idle(3);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ack", ack_received, 0);
    chk("rst_ready", cmd_ready, 1);
    rst_n = 1'b1;
    idle(4);

    // Write A0 with START and STOP, subordinate ACKs.
    d0 = ndone; s0 = n_start; p0 = n_stop;
    push_exp(1'b0, 8'h00, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 1'b1, 1'b0, 8'hA0);
    wait_done("wr_a0");
    check_sb("wr_a0");
    check_mq("wr_a0", {8'hA0, 1'b0});
    idle(10);
    chk("wr_a0_ndone", ndone - d0, 1);
    chk("wr_a0_starts", n_start - s0, 1);
    chk("wr_a0_stops", n_stop - p0, 1);
    chk("wr_a0_ready", cmd_ready, 1);

    // Command without START from IDLE is ignored but still completes.
    s0 = n_start;
    push_exp(1'b0, 8'h00, 1'b1, 1'b0);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);
    wait_done("ignored");
    check_sb("ignored");
    idle(10);
    chk("ignored_no_start", n_start - s0, 0);

    // Nobody answers: NACK seen, STOP still issued.
    m_ack = 1'b0; p0 = n_stop;
    push_exp(1'b0, 8'h00, 1'b1, 1'b0);
    issue(1'b1, 1'b0, 1'b1, 1'b0, 8'h3C);
    wait_done("noresp");
    check_sb("noresp");
    check_mq("noresp", {8'h3C, 1'b1});
    idle(5);
    chk("noresp_stops", n_stop - p0, 1);
    chk("noresp_idle", cmd_ready, 1);
    m_ack = 1'b1;

    // Read 5C with NACK then STOP.
    m_rd = 1'b1; m_byte = 8'h5C; p0 = n_stop;
    push_exp(1'b1, 8'h5C, 1'b0, 1'b0);
    issue(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    wait_done("rd_5c");
    check_sb("rd_5c");
    check_mq("rd_5c", {8'h5C, 1'b1});
    idle(5);
    chk("rd_5c_stops", n_stop - p0, 1);
    m_rd = 1'b0;

    // Clock stretching of 50 clk on data bit 3.
    st_en = 1'b1;
    push_exp(1'b0, 8'h00, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 1'b1, 1'b0, 8'h96);
    wait_done("stretch");
    check_sb("stretch");
    check_mq("stretch", {8'h96, 1'b0});
    chk("stretch_low_len", st_lo >= 50, 1);
    chk("stretch_high_len", (st_hi >= 2 * K) && (st_hi <= 2 * K + 4), 1);
    st_en = 1'b0;
    idle(5);

    // Write without STOP parks in HOLD, then repeated START and read.
    push_exp(1'b0, 8'h00, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 1'b0, 1'b0, 8'hA0);
    wait_done("hold_wr");
    check_sb("hold_wr");
    check_mq("hold_wr", {8'hA0, 1'b0});
    idle(8);
    chk("hold_scl_low", scl_oe, 1);
    chk("hold_sda_rel", sda_oe, 0);
    chk("hold_ready", cmd_ready, 1);
    m_rd = 1'b1; m_byte = 8'hC3; s0 = n_start; p0 = n_stop;
    push_exp(1'b1, 8'hC3, 1'b0, 1'b0);
    issue(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    wait_done("rs_rd");
    check_sb("rs_rd");
    check_mq("rs_rd", {8'hC3, 1'b1});
    idle(5);
    chk("rs_starts", n_start - s0, 1);
    chk("rs_stops", n_stop - p0, 1);
    m_rd = 1'b0;

    // Reset in the middle of a byte, then a normal transfer.
    issue(1'b1, 1'b0, 1'b1, 1'b0, 8'h55);
    idle(60);
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_scl_oe", scl_oe, 0);
    chk("mid_rst_sda_oe", sda_oe, 0);
    chk("mid_rst_busy", busy, 0);
    idle(3);
    rst_n = 1'b1;
    idle(4);
    push_exp(1'b0, 8'h00, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 1'b1, 1'b0, 8'h69);
    wait_done("post_rst");
    check_sb("post_rst");
    check_mq("post_rst", {8'h69, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
